// File: rtl/alu_operand_scheduler.sv
// alu_operand_scheduler: EX-stage operand forwarding selects plus load-use stall / bubble control.
// Latency: selects and stall are combinational (selects from registered records only); ex_bubble is 1 the cycle after a stall edge.
// Backpressure: stall holds PC and IF/ID for one cycle; flush overrides stall. Define ALU_HAZARD_PERF_EN to add stall_count.
module alu_operand_scheduler #(
    parameter int REG_ADDR_W = 3,
    parameter int SEL_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_reg_write,
    input  logic                  dec_is_load,
    input  logic                  dec_is_in,
    input  logic                  flush,
    output logic [SEL_W-1:0]      alu_src1_sel,
    output logic [SEL_W-1:0]      alu_src2_sel,
    output logic                  stall,
    output logic                  ex_bubble
`ifdef ALU_HAZARD_PERF_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    localparam logic [SEL_W-1:0] SEL_WB     = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_MEM    = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_REG    = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_IN_EX  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_IN_MEM = SEL_W'(4);

    // Full decode record for the instruction currently in EX.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  is_in;
    } ex_rec_t;

    // Past EX only the producer side matters: sources are never consulted again.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  is_in;
    } mem_rec_t;

    ex_rec_t               r_ex;
    ex_rec_t               w_ex_next;
    mem_rec_t              r_mem;
    // WB keeps only writers: a non-writing producer never forwards.
    logic                  r_wb_fwd;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_ex_bubble;
    logic                  w_load_hit;

    // Priority select for one operand; op2 with an immediate always takes the register/immediate path.
    function automatic logic [SEL_W-1:0] f_pick(
        input logic                  ex_valid,
        input logic                  ex_is_in,
        input mem_rec_t              mem,
        input logic                  wb_fwd,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  used,
        input logic                  is_op2
    );
        logic [SEL_W-1:0] sel;
        sel = SEL_REG;
        if (!ex_valid) begin
            sel = SEL_REG;
        end else if (is_op2 && !used) begin
            sel = SEL_REG;
        end else if (ex_is_in) begin
            sel = SEL_IN_EX;
        end else if (used && mem.valid && mem.reg_write && (mem.rd == src)) begin
            // A load in MEM cannot be forwarded; stall logic keeps this case from arising.
            if (mem.is_in)        sel = SEL_IN_MEM;
            else if (mem.is_load) sel = SEL_REG;
            else                  sel = SEL_MEM;
        end else if (wb_fwd && (wb_rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Load-use detection against the decode sources; flush always wins.
    always_comb begin
        w_load_hit = r_ex.valid && r_ex.is_load && r_ex.reg_write &&
                     ((dec_rs1_used && (dec_rs1 == r_ex.rd)) ||
                      (dec_rs2_used && (dec_rs2 == r_ex.rd)));
        stall      = dec_valid && w_load_hit && !flush;
    end

    // Next EX content: the decoded instruction, or a bubble on stall/flush/no-instruction.
    always_comb begin
        w_ex_next = '0;
        if (dec_valid && !stall && !flush) begin
            w_ex_next.valid     = 1'b1;
            w_ex_next.rs1       = dec_rs1;
            w_ex_next.rs2       = dec_rs2;
            w_ex_next.rs1_used  = dec_rs1_used;
            w_ex_next.rs2_used  = dec_rs2_used;
            w_ex_next.rd        = dec_rd;
            w_ex_next.reg_write = dec_reg_write;
            w_ex_next.is_load   = dec_is_load;
            w_ex_next.is_in     = dec_is_in;
        end
    end

    // Advance the EX -> MEM -> WB records every cycle; remember stall-injected bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb_fwd    <= 1'b0;
            r_wb_rd     <= '0;
            r_ex_bubble <= 1'b0;
        end else begin
            r_ex            <= w_ex_next;
            r_mem.valid     <= r_ex.valid;
            r_mem.rd        <= r_ex.rd;
            r_mem.reg_write <= r_ex.reg_write;
            r_mem.is_load   <= r_ex.is_load;
            r_mem.is_in     <= r_ex.is_in;
            r_wb_fwd        <= r_mem.valid && r_mem.reg_write;
            r_wb_rd         <= r_mem.rd;
            r_ex_bubble     <= stall;
        end
    end

    // Operand selects depend on registered records only, so they hold for the whole EX cycle.
    always_comb begin
        alu_src1_sel = f_pick(r_ex.valid, r_ex.is_in, r_mem, r_wb_fwd, r_wb_rd,
                              r_ex.rs1, r_ex.rs1_used, 1'b0);
        alu_src2_sel = f_pick(r_ex.valid, r_ex.is_in, r_mem, r_wb_fwd, r_wb_rd,
                              r_ex.rs2, r_ex.rs2_used, 1'b1);
        ex_bubble    = r_ex_bubble;
    end

`ifdef ALU_HAZARD_PERF_EN
    logic [15:0] r_stall_count;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_alu_operand_scheduler.sv
// tb_alu_operand_scheduler: directed test-plan scenarios followed by random instruction streams.
// Reference keeps a 3-deep history of issued slots (EX, one older, two older) and derives selects from it.
// Every cycle compares selects, stall, ex_bubble (and stall_count when enabled) against the reference.
module tb_alu_operand_scheduler;

    logic       clk;
    logic       rst_n;
    logic       dec_valid;
    logic [2:0] dec_rs1;
    logic [2:0] dec_rs2;
    logic       dec_rs1_used;
    logic       dec_rs2_used;
    logic [2:0] dec_rd;
    logic       dec_reg_write;
    logic       dec_is_load;
    logic       dec_is_in;
    logic       flush;
    logic [2:0] alu_src1_sel;
    logic [2:0] alu_src2_sel;
    logic       stall;
    logic       ex_bubble;
`ifdef ALU_HAZARD_PERF_EN
    logic [15:0] stall_count;
`endif

    alu_operand_scheduler #(.REG_ADDR_W(3), .SEL_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_reg_write(dec_reg_write),
        .dec_is_load  (dec_is_load),
        .dec_is_in    (dec_is_in),
        .flush        (flush),
        .alu_src1_sel (alu_src1_sel),
        .alu_src2_sel (alu_src2_sel),
        .stall        (stall),
        .ex_bubble    (ex_bubble)
`ifdef ALU_HAZARD_PERF_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [2:0] rs1;
        bit [2:0] rs2;
        bit       u1;
        bit       u2;
        bit [2:0] rd;
        bit       wr;
        bit       ld;
        bit       inp;
    } ins_t;

    ins_t hist [3];     // [0] = in EX, [1] = one stage older, [2] = two stages older
    bit   m_bubble;
    int   m_stalls;
    int   vectors;
    int   miscompares;

    function automatic ins_t nop();
        ins_t n;
        n = '{default: 0};
        return n;
    endfunction

    function automatic ins_t mk(int rd, int rs1, int rs2, bit u1, bit u2, bit wr, bit ld, bit inp);
        ins_t r;
        r.v = 1'b1; r.rd = 3'(rd); r.rs1 = 3'(rs1); r.rs2 = 3'(rs2);
        r.u1 = u1; r.u2 = u2; r.wr = wr; r.ld = ld; r.inp = inp;
        return r;
    endfunction

    // Where the EX instruction's operand should come from, by the forwarding rules.
    function automatic int ref_sel(int op);
        ins_t e;
        bit [2:0] src;
        bit used;
        e    = hist[0];
        src  = (op == 1) ? e.rs1 : e.rs2;
        used = (op == 1) ? e.u1 : e.u2;
        if (!e.v) return 2;
        if (op == 2 && !used) return 2;
        if (e.inp) return 3;
        if (used && hist[1].v && hist[1].wr && hist[1].rd == src)
            return hist[1].inp ? 4 : (hist[1].ld ? 2 : 1);
        if (hist[2].v && hist[2].wr && hist[2].rd == src) return 0;
        return 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = nop();
        m_bubble = 1'b0;
        m_stalls = 0;
    endtask

    // Called at posedge+1: drive decode, check all outputs, clock, advance the reference.
    task automatic apply(input ins_t d, input bit fl, output bit obs_st);
        bit   exp_st;
        ins_t nxt;
        dec_valid = d.v; dec_rs1 = d.rs1; dec_rs2 = d.rs2;
        dec_rs1_used = d.u1; dec_rs2_used = d.u2; dec_rd = d.rd;
        dec_reg_write = d.wr; dec_is_load = d.ld; dec_is_in = d.inp; flush = fl;
        #1;
        exp_st = !fl && d.v && hist[0].v && hist[0].ld && hist[0].wr &&
                 ((d.u1 && d.rs1 == hist[0].rd) || (d.u2 && d.rs2 == hist[0].rd));
        chk("sel1", alu_src1_sel, ref_sel(1));
        chk("sel2", alu_src2_sel, ref_sel(2));
        chk("stall", stall, int'(exp_st));
        chk("ex_bubble", ex_bubble, int'(m_bubble));
`ifdef ALU_HAZARD_PERF_EN
        chk("stall_count", stall_count, m_stalls);
`endif
        obs_st = stall;
        @(posedge clk);
        #1;
        nxt = (d.v && !exp_st && !fl) ? d : nop();
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = nxt;
        m_bubble = exp_st;
        if (exp_st && m_stalls < 65535) m_stalls++;
    endtask

    task automatic expect_sel(input string tag, input int e1, input int e2);
        chk({tag, "_sel1"}, alu_src1_sel, e1);
        chk({tag, "_sel2"}, alu_src2_sel, e2);
    endtask

    initial begin
        bit   st;
        ins_t r;
        int   k;
        vectors = 0;
        miscompares = 0;
        model_reset();
        rst_n = 1'b0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_reg_write = 0; dec_is_load = 0; dec_is_in = 0; flush = 0;
        #1;
        expect_sel("rst", 2, 2);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", ex_bubble, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back ALU: ADD R1,R2,R3 ; SUB R4,R1,R5
        apply(mk(1, 2, 3, 1, 1, 1, 0, 0), 0, st);
        apply(mk(4, 1, 5, 1, 1, 1, 0, 0), 0, st);
        expect_sel("b2b", 1, 2);

        // Distance 2 through a NOP: ADD R1 ; NOP ; OR R6,R7,R1
        apply(mk(1, 2, 3, 1, 1, 1, 0, 0), 0, st);
        apply(nop(), 0, st);
        apply(mk(6, 7, 1, 1, 1, 1, 0, 0), 0, st);
        expect_sel("dist2", 2, 0);

        // Younger writer of R1 in between takes priority
        apply(mk(1, 2, 3, 1, 1, 1, 0, 0), 0, st);
        apply(mk(1, 3, 2, 1, 1, 1, 0, 0), 0, st);
        apply(mk(6, 7, 1, 1, 1, 1, 0, 0), 0, st);
        expect_sel("memprio", 2, 1);

        // Mid-stream reset while a load-use stall is pending
        apply(mk(3, 0, 0, 1, 0, 1, 1, 0), 0, st);
        dec_valid = 1; dec_rs1 = 3; dec_rs1_used = 1; dec_rs2_used = 0; flush = 0;
        #1;
        chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        expect_sel("midrst", 2, 2);
        chk("midrst_stall", stall, 0);
        chk("midrst_bubble", ex_bubble, 0);
        model_reset();
`ifdef ALU_HAZARD_PERF_EN
        chk("midrst_count", stall_count, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use: LDD R2 ; ADD R3,R2,R2
        apply(mk(2, 0, 0, 1, 0, 1, 1, 0), 0, st);
        apply(mk(3, 2, 2, 1, 1, 1, 0, 0), 0, st);
        chk("lu_stall", st, 1);
        chk("lu_bubble", ex_bubble, 1);
        expect_sel("lu_bub", 2, 2);
        apply(mk(3, 2, 2, 1, 1, 1, 0, 0), 0, st);
        chk("lu_stall_once", st, 0);
        chk("lu_bubble_clear", ex_bubble, 0);
        expect_sel("lu_cons", 0, 0);
`ifdef ALU_HAZARD_PERF_EN
        chk("lu_count", stall_count, 1);
`endif

        // IN forwarding: IN R5 ; NOT R5
        apply(mk(5, 0, 0, 0, 1, 1, 0, 1), 0, st);
        chk("in_ex_sel2", alu_src2_sel, 3);
        apply(mk(5, 5, 0, 1, 0, 1, 0, 0), 0, st);
        expect_sel("in_mem", 4, 2);

        // Flush beats load-use stall
        apply(mk(4, 0, 0, 1, 0, 1, 1, 0), 0, st);
        apply(mk(1, 4, 4, 1, 1, 1, 0, 0), 1, st);
        chk("flush_stall", st, 0);
        chk("flush_bubble", ex_bubble, 0);
        expect_sel("flush", 2, 2);

        // Random streams over a small register window to provoke many hazards
        for (int n = 0; n < 600; n++) begin
            r.v   = ($urandom_range(0, 7) != 0);
            r.rs1 = 3'($urandom_range(0, 3));
            r.rs2 = 3'($urandom_range(0, 3));
            r.rd  = 3'($urandom_range(0, 3));
            r.u1  = 1'($urandom_range(0, 1));
            r.u2  = 1'($urandom_range(0, 1));
            r.wr  = ($urandom_range(0, 3) != 0);
            k     = $urandom_range(0, 5);
            r.ld  = (k <= 1);
            r.inp = (k == 2);
            apply(r, ($urandom_range(0, 7) == 0), st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
